// File: rtl/grayscale_if.sv
// Pixel FIFO handshake bundle for the grayscale stage: FWFT input pop side
// and output push side. The slave modport is the grayscale block's view.
interface grayscale_if;
  localparam int unsigned PIX_W = 24;

  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;

  modport master (
    input  in_rd_en,
    input  out_wr_en,
    input  out_din,
    output in_empty,
    output in_dout,
    output out_full
  );

  modport slave (
    output in_rd_en,
    output out_wr_en,
    output out_din,
    input  in_empty,
    input  in_dout,
    input  out_full
  );
endinterface

// File: rtl/grayscale.sv
// RGB -> 8-bit gray converter, two-register pipeline with backpressure.
// Macro GRAYSCALE_WEIGHTED_EN selects 77/150/29 luma weights instead of (R+G+B)/3.
module grayscale (
  input  logic      clock,
  input  logic      reset,
  grayscale_if.slave px
);

  localparam int unsigned CH_W   = 8;
`ifdef GRAYSCALE_WEIGHTED_EN
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned W_R    = 77;
  localparam int unsigned W_G    = 150;
  localparam int unsigned W_B    = 29;
`else
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned PROD_W = 20;
  localparam int unsigned RECIP3 = 683;
  localparam int unsigned RSHIFT = 11;
`endif

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [SUM_W-1:0] sum1_q, sum1_d;
  logic [CH_W-1:0]  gray2_q, gray2_d;

  logic             adv1_c, adv2_c;
  logic             rd_c, wr_c;
  logic [CH_W-1:0]  r_c, g_c, b_c;
  logic [SUM_W-1:0] sum_c;
  logic [CH_W-1:0]  gray_c;
`ifndef GRAYSCALE_WEIGHTED_EN
  logic [PROD_W-1:0] prod_c;
`endif

  // Channel split and arithmetic for both stages
  always_comb begin
    r_c = px.in_dout[23:16];
    g_c = px.in_dout[15:8];
    b_c = px.in_dout[7:0];
`ifdef GRAYSCALE_WEIGHTED_EN
    sum_c  = SUM_W'(r_c) * SUM_W'(W_R)
           + SUM_W'(g_c) * SUM_W'(W_G)
           + SUM_W'(b_c) * SUM_W'(W_B);
    gray_c = CH_W'(sum1_q >> CH_W);
`else
    sum_c  = SUM_W'(r_c) + SUM_W'(g_c) + SUM_W'(b_c);
    // 683/2048 gives exact floor(x/3) over 0..765
    prod_c = PROD_W'(sum1_q) * PROD_W'(RECIP3);
    gray_c = CH_W'(prod_c >> RSHIFT);
`endif
  end

  // Handshake: a stage advances when it is empty or its consumer accepts
  always_comb begin
    adv2_c = !v2_q || !px.out_full;
    adv1_c = !v1_q || adv2_c;
    rd_c   = !px.in_empty && adv1_c;
    wr_c   = v2_q && !px.out_full;
  end

  // Next-state for both pipeline registers; hold when not advancing
  always_comb begin
    v1_d    = v1_q;
    sum1_d  = sum1_q;
    v2_d    = v2_q;
    gray2_d = gray2_q;
    if (adv1_c) begin
      v1_d = rd_c;
      if (rd_c) begin
        sum1_d = sum_c;
      end
    end
    if (adv2_c) begin
      v2_d    = v1_q;
      gray2_d = gray_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      sum1_q  <= '0;
      v2_q    <= 1'b0;
      gray2_q <= '0;
    end else begin
      v1_q    <= v1_d;
      sum1_q  <= sum1_d;
      v2_q    <= v2_d;
      gray2_q <= gray2_d;
    end
  end

  // Pop/push strobes must react to FIFO flags in the same cycle
  always_comb begin
    px.in_rd_en  = rd_c;
    px.out_wr_en = wr_c;
    px.out_din   = wr_c ? {gray2_q, gray2_q, gray2_q} : 24'h0;
  end

endmodule

// File: tb/tb_grayscale.sv
// Directed self-checking bench for grayscale: FWFT source model, write capture,
// hand-computed expectations checked with immediate assertions.
module tb_grayscale;

  logic clock = 1'b0;
  logic reset = 1'b0;

  grayscale_if ifc ();

  grayscale dut (
    .clock (clock),
    .reset (reset),
    .px    (ifc.slave)
  );

  always #5 clock = ~clock;

`ifdef GRAYSCALE_WEIGHTED_EN
  localparam logic [23:0] EXP_RED = 24'h4C4C4C;
`else
  localparam logic [23:0] EXP_RED = 24'h555555;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        hold_empty = 1'b0;
  logic [23:0] src[$];
  logic [23:0] got[$];
  int          wr_cyc[$];
  int          pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ifc.in_empty = hold_empty || (src.size() == 0);
    ifc.in_dout  = (src.size() != 0) ? src[0] : 24'h0;
  endtask

  // One clock: sample strobes mid-cycle, apply FIFO effects at the edge
  task automatic tick();
    logic rd, wr;
    logic [23:0] din;
    @(negedge clock);
    rd  = ifc.in_rd_en;
    wr  = ifc.out_wr_en;
    din = ifc.out_din;
    @(posedge clock);
    if (reset && rd && src.size() != 0) begin
      void'(src.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (reset && wr) begin
      got.push_back(din);
      wr_cyc.push_back(cyc);
    end
    cyc++;
    #1 drive();
  endtask

  task automatic clear_log();
    got.delete();
    wr_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int b = 0;
    while (got.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk(tag, got.size(), n);
  endtask

  initial begin
    logic [7:0] k8;
    ifc.out_full = 1'b0;
    drive();

    // Reset state
    #2;
    chk("rst_rd_empty", ifc.in_rd_en, 0);
    chk("rst_wr", ifc.out_wr_en, 0);
    chk("rst_din", ifc.out_din, 0);
    ifc.in_empty = 1'b0;
    #1 chk("rst_rd_follows_empty", ifc.in_rd_en, 1);
    drive();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    tick();

    // Basic stream and latency
    clear_log();
    src.push_back(24'hFFFFFF);
    src.push_back(24'h000000);
    src.push_back(24'h030201);
    drive();
    run_until(3, 12, "stream_count");
    chk("stream_px0", got[0], 24'hFFFFFF);
    chk("stream_px1", got[1], 24'h000000);
    chk("stream_px2", got[2], 24'h020202);
    chk("latency", wr_cyc[0] - pop_cyc[0], 2);
    chk("back2back_1", wr_cyc[1] - wr_cyc[0], 1);
    chk("back2back_2", wr_cyc[2] - wr_cyc[0], 2);

    // Pure red pixel
    clear_log();
    src.push_back(24'hFF0000);
    drive();
    run_until(1, 10, "red_count");
    chk("red_value", got[0], EXP_RED);

    // Backpressure: 8 pixels, output full for 5 cycles
    clear_log();
    for (int i = 0; i < 8; i++) begin
      k8 = 8'(8'h11 * (i + 1));
      src.push_back({k8, k8, k8});
    end
    drive();
    run_until(1, 10, "stall_first");
    ifc.out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rd", ifc.in_rd_en, 0);
      chk("stall_wr", ifc.out_wr_en, 0);
      tick();
    end
    chk("stall_no_write", got.size(), 1);
    ifc.out_full = 1'b0;
    #1 chk("unstall_wr_same_cycle", ifc.out_wr_en, 1);
    run_until(8, 30, "stall_count");
    for (int i = 0; i < 8; i++) begin
      k8 = 8'(8'h11 * (i + 1));
      chk($sformatf("stall_px%0d", i), got[i], {k8, k8, k8});
    end

    // Input empty toggling every cycle
    clear_log();
    for (int i = 0; i < 4; i++) begin
      k8 = 8'(8'h20 * (i + 1));
      src.push_back({k8, k8, k8});
    end
    for (int i = 0; i < 12; i++) begin
      hold_empty = (i % 2 == 0);
      drive();
      tick();
    end
    hold_empty = 1'b0;
    drive();
    chk("toggle_pops", pop_cyc.size(), 4);
    chk("toggle_writes", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      k8 = 8'(8'h20 * (i + 1));
      chk($sformatf("toggle_px%0d", i), got[i], {k8, k8, k8});
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("toggle_gap%0d", i), wr_cyc[i + 1] - wr_cyc[i], 2);
    end

    // Reset with both stages full
    clear_log();
    ifc.out_full = 1'b1;
    src.push_back(24'h404040);
    src.push_back(24'h505050);
    drive();
    repeat (4) tick();
    chk("prerst_pops", pop_cyc.size(), 2);
    chk("prerst_no_write", got.size(), 0);
    ifc.out_full = 1'b0;
    #1 chk("prerst_wr_pending", ifc.out_wr_en, 1);
    reset = 1'b0;
    #1;
    chk("midrst_wr", ifc.out_wr_en, 0);
    chk("midrst_din", ifc.out_din, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive();
    repeat (6) tick();
    chk("postrst_no_write", got.size(), 0);

    // Gray sweep k = 0..255
    clear_log();
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      src.push_back({k8, k8, k8});
    end
    drive();
    run_until(256, 400, "sweep_count");
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      chk($sformatf("sweep_%0d", k), got[k], {k8, k8, k8});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
